tcdm_req_spill: RTL and testbench
=================================

Name: tcdm_req_spill

Overview:
- Two-entry request spill/skid register with grant-based flow control.
- Sits directly downstream of the root of the request multiplexer tree, in front of a TCDM bank port.
- Cuts every combinational path between the two sides: the mux tree's req/gnt/add/wen/wdata/be/ID path and the bank's grant path.
- Sustains one request per cycle, preserves order, and holds requests stable under back-pressure.

Parameters:
- ID_WIDTH, 20, width of the requester ID field.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, write data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous flush of all buffered requests.
- data_req_i  input  1  upstream request valid.
- data_add_i  input  ADDR_WIDTH  upstream address.
- data_wen_i  input  1  upstream write enable; 1 = read, 0 = write.
- data_wdata_i  input  DATA_WIDTH  upstream write data.
- data_be_i  input  BE_WIDTH  upstream byte enables.
- data_ID_i  input  ID_WIDTH  upstream requester ID.
- data_gnt_o  output  1  upstream grant.
- data_req_o  output  1  downstream request valid.
- data_add_o  output  ADDR_WIDTH  downstream address.
- data_wen_o  output  1  downstream write enable.
- data_wdata_o  output  DATA_WIDTH  downstream write data.
- data_be_o  output  BE_WIDTH  downstream byte enables.
- data_ID_o  output  ID_WIDTH  downstream requester ID.
- data_gnt_i  input  1  downstream grant.
- count_o  output  2  occupancy, 0..2.

Behaviour:
- Handshakes:
  - push = data_req_i & data_gnt_o; pop = data_req_o & data_gnt_i.
  - A transfer occurs only when req and gnt are both high in the same cycle.
- Storage: slot A (head, drives all data_*_o outputs) and slot B (skid). Each slot holds {add, wen, wdata, be, ID}.
- State: EMPTY (count 0), ONE (count 1), TWO (count 2). count_o is the state encoding, registered.
- Output decode (registered state only; no input-to-output combinational path):
  - data_req_o = (state != EMPTY).
  - data_gnt_o = (state != TWO) & ~clear_i.
  - data_gnt_o does NOT depend on data_req_i or data_gnt_i.
- Transitions (clear_i = 0):
  - EMPTY: push -> A <= in, ONE. Otherwise stay.
  - ONE, push & pop -> A <= in, stay ONE.
  - ONE, push only -> B <= in, TWO.
  - ONE, pop only -> EMPTY.
  - ONE, neither -> hold.
  - TWO: no push is possible. pop -> A <= B, ONE; otherwise hold.
- Latency and throughput:
  - A request accepted at edge n appears on data_req_o after edge n (1 cycle); no combinational bypass.
  - With data_gnt_i held high: 1 transfer/cycle, steady state ONE.
- Stability: while data_req_o = 1 and data_gnt_i = 0, all data_*_o outputs hold their value unchanged.
- Ordering: strict FIFO; B is never output before A.
- clear_i:
  - Next state EMPTY and both slots invalidated, regardless of push/pop.
  - data_gnt_o is 0 during clear, so no upstream request is lost silently.
  - A downstream pop in the clear cycle still completes at the bank, but the entry is discarded from the buffer.
- Reset:
  - State EMPTY, count_o = 0, data_req_o = 0, data_gnt_o = 1.
  - All slot fields reset to 0, so data_*_o = 0.
  - Reset asserted mid-operation discards all contents immediately (asynchronous).
- Data registers load only on the enables above; no X propagation from idle inputs into A/B.

Test Plan:
- Single write: after reset, req_i = 1, add = 0x100, wen = 0, wdata = 0xDEADBEEF, be = 0xF, ID = 0x3, gnt_i = 1 -> next cycle req_o = 1 with identical fields; the cycle after, req_o = 0 and count_o = 0.
- Streaming: 8 back-to-back reads, add = 0x0..0x1C step 4, gnt_i = 1 throughout -> gnt_o stays 1, outputs appear in order one per cycle, 1-cycle latency, count_o = 1 steady.
- Back-pressure: gnt_i = 0, push 3 requests (A1, A2, A3) -> gnt_o drops to 0 after the 2nd push, count_o = 2, A3 held upstream, outputs stay A1. Then raise gnt_i -> order A1, A2, A3, gnt_o returns to 1 the cycle after the first pop.
- Simultaneous push/pop in ONE: count_o stays 1 and the head advances each cycle. Check with random gnt_i against a scoreboard over 1000 requests: no loss, no duplication, order kept.
- clear_i asserted with count_o = 2 and req_i = 1 -> gnt_o = 0 that cycle, next cycle count_o = 0 and req_o = 0; the pending upstream request is accepted afterwards.
- rst_n pulsed low with count_o = 2 -> req_o = 0, count_o = 0 and data_*_o = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tcdm_req_spill.sv
// Two-entry request spill register between the request mux tree and a TCDM bank port.
// Slot A is the head and drives the bank. Slot B absorbs one request while the bank stalls.
module tcdm_req_spill #(
  parameter int unsigned ID_WIDTH   = 20,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [ID_WIDTH-1:0]   data_ID_o,
  input  logic                  data_gnt_i,
  output logic [1:0]            count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic [ID_WIDTH-1:0]   id;
  } slot_t;

  state_e state_q, state_d;
  slot_t  slot_a_q, slot_b_q, slot_in;
  logic   push, pop;
  logic   load_a_in, load_a_b, load_b_in;

  assign slot_in = '{add: data_add_i, wen: data_wen_i, wdata: data_wdata_i,
                     be: data_be_i, id: data_ID_i};

  // Both handshake outputs decode registered state only, so no path crosses the buffer.
  assign data_req_o = (state_q != EMPTY);
  assign data_gnt_o = (state_q != TWO) & ~clear_i;
  assign push       = data_req_i & data_gnt_o;
  assign pop        = data_req_o & data_gnt_i;
  assign count_o    = state_q;

  assign data_add_o   = slot_a_q.add;
  assign data_wen_o   = slot_a_q.wen;
  assign data_wdata_o = slot_a_q.wdata;
  assign data_be_o    = slot_a_q.be;
  assign data_ID_o    = slot_a_q.id;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    load_a_in = 1'b0;
    load_a_b  = 1'b0;
    load_b_in = 1'b0;
    if (clear_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            load_a_in = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_a_in = 1'b1;
          end else if (push) begin
            load_b_in = 1'b1;
            state_d   = TWO;
          end else if (pop) begin
            state_d   = EMPTY;
          end
        end
        TWO: begin
          // gnt_o is low here, so only the head can leave; the skid entry moves up.
          if (pop) begin
            load_a_b = 1'b1;
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: the slots are reset because the bank-side fields must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_a_q <= '0;
      slot_b_q <= '0;
    end else begin
      if (load_a_in)     slot_a_q <= slot_in;
      else if (load_a_b) slot_a_q <= slot_b_q;
      if (load_b_in)     slot_b_q <= slot_in;
    end
  end

endmodule

// File: tb/tb_tcdm_req_spill.sv
// Randomized scoreboard bench for tcdm_req_spill: accepted requests queue up, and the
// negedge monitor checks head, occupancy and handshake outputs against that queue.
module tb_tcdm_req_spill;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [19:0] id;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_i = 1'b0;
  logic        data_req_i = 1'b0;
  logic [31:0] data_add_i = '0;
  logic        data_wen_i = 1'b0;
  logic [31:0] data_wdata_i = '0;
  logic [3:0]  data_be_i = '0;
  logic [19:0] data_ID_i = '0;
  logic        data_gnt_o;
  logic        data_req_o;
  logic [31:0] data_add_o;
  logic        data_wen_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_be_o;
  logic [19:0] data_ID_o;
  logic        data_gnt_i = 1'b0;
  logic [1:0]  count_o;

  int   checks = 0;
  int   failures = 0;
  int   accepted = 0;
  req_t exp_q[$];

  tcdm_req_spill dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear_i),
    .data_req_i   (data_req_i),
    .data_add_i   (data_add_i),
    .data_wen_i   (data_wen_i),
    .data_wdata_i (data_wdata_i),
    .data_be_i    (data_be_i),
    .data_ID_i    (data_ID_i),
    .data_gnt_o   (data_gnt_o),
    .data_req_o   (data_req_o),
    .data_add_o   (data_add_o),
    .data_wen_o   (data_wen_o),
    .data_wdata_o (data_wdata_o),
    .data_be_o    (data_be_o),
    .data_ID_o    (data_ID_o),
    .data_gnt_i   (data_gnt_i),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic req_t out_word();
    return {data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o};
  endfunction

  function automatic req_t in_word();
    return {data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i};
  endfunction

  // Reference model: the buffer is an ordered queue of accepted requests holding at most two.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_gnt;
      exp_gnt = (exp_q.size() < 2) && !clear_i;
      check("count", count_o, exp_q.size());
      check("req_o", data_req_o, exp_q.size() != 0);
      check("gnt_o", data_gnt_o, exp_gnt);
      if (exp_q.size() != 0) check("head", out_word(), exp_q[0]);
      if (data_req_o && data_gnt_i && exp_q.size() != 0) void'(exp_q.pop_front());
      if (clear_i) exp_q.delete();
      else if (data_req_i && exp_gnt) begin
        exp_q.push_back(in_word());
        accepted++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] add, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] be, input logic [19:0] id);
    data_req_i   = req;
    data_add_i   = add;
    data_wen_i   = wen;
    data_wdata_i = wdata;
    data_be_i    = be;
    data_ID_i    = id;
  endtask

  initial begin
    int cyc;
    // Reset state
    #2;
    check("rst_count", count_o, 2'd0);
    check("rst_req_o", data_req_o, 1'b0);
    check("rst_gnt_o", data_gnt_o, 1'b1);
    check("rst_data", out_word(), '0);
    step();
    rst_n = 1'b1;
    step();

    // Single write
    data_gnt_i = 1'b1;
    drive(1'b1, 32'h100, 1'b0, 32'hDEADBEEF, 4'hF, 20'h3);
    step();
    check("sw_req_o", data_req_o, 1'b1);
    check("sw_fields", out_word(), {32'h100, 1'b0, 32'hDEADBEEF, 4'hF, 20'h3});
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    step();
    check("sw_req_o_after", data_req_o, 1'b0);
    check("sw_count_after", count_o, 2'd0);

    // Streaming reads, grant held high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 32'h0, 4'hF, 20'(i + 16));
      step();
      check("st_count", count_o, 2'd1);
      check("st_gnt_o", data_gnt_o, 1'b1);
      check("st_add", data_add_o, 32'(i * 4));
    end
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    step();
    check("st_drained", count_o, 2'd0);

    // Back-pressure
    data_gnt_i = 1'b0;
    drive(1'b1, 32'hA1, 1'b0, 32'h1111, 4'h1, 20'hA1);
    step();
    drive(1'b1, 32'hA2, 1'b0, 32'h2222, 4'h2, 20'hA2);
    step();
    check("bp_count_full", count_o, 2'd2);
    check("bp_gnt_low", data_gnt_o, 1'b0);
    drive(1'b1, 32'hA3, 1'b1, 32'h3333, 4'h4, 20'hA3);
    step();
    step();
    check("bp_hold_count", count_o, 2'd2);
    check("bp_hold_head", data_add_o, 32'hA1);
    data_gnt_i = 1'b1;
    step();
    check("bp_pop1_head", data_add_o, 32'hA2);
    check("bp_pop1_gnt", data_gnt_o, 1'b1);
    step();
    check("bp_pop2_head", data_add_o, 32'hA3);
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    step();
    check("bp_drained", count_o, 2'd0);

    // Clear while full with a pending upstream request
    data_gnt_i = 1'b0;
    drive(1'b1, 32'hC1, 1'b0, 32'h5, 4'h1, 20'hC1);
    step();
    drive(1'b1, 32'hC2, 1'b0, 32'h6, 4'h2, 20'hC2);
    step();
    drive(1'b1, 32'hC3, 1'b0, 32'h7, 4'h3, 20'hC3);
    clear_i = 1'b1;
    #1;
    check("clr_gnt_low", data_gnt_o, 1'b0);
    step();
    clear_i = 1'b0;
    check("clr_count", count_o, 2'd0);
    check("clr_req_o", data_req_o, 1'b0);
    step();
    check("clr_pending_taken", data_add_o, 32'hC3);
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    data_gnt_i = 1'b1;
    step();
    step();

    // Randomized traffic: 1000 accepted requests against the queue model
    cyc = 0;
    accepted = 0;
    while (accepted < 1000 && cyc < 20000) begin
      drive($urandom_range(0, 9) < 7, $urandom, 1'($urandom), $urandom, 4'($urandom),
            20'($urandom));
      data_gnt_i = 1'($urandom);
      clear_i    = ($urandom_range(0, 99) == 0);
      step();
      cyc++;
    end
    check("rand_budget", accepted >= 1000, 1'b1);
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    clear_i    = 1'b0;
    data_gnt_i = 1'b1;
    step();
    step();
    step();
    check("rand_drained", count_o, 2'd0);

    // Asynchronous reset while full
    data_gnt_i = 1'b0;
    drive(1'b1, 32'hE1, 1'b1, 32'h9, 4'hF, 20'hE1);
    step();
    drive(1'b1, 32'hE2, 1'b1, 32'hA, 4'hF, 20'hE2);
    step();
    check("ar_full", count_o, 2'd2);
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("ar_count", count_o, 2'd0);
    check("ar_req_o", data_req_o, 1'b0);
    check("ar_data", out_word(), '0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_after", data_req_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
